// File: rtl/fma_dot_seq_pkg.sv
// Shared types and default widths for the fma_dot_seq dot-product sequencer.
package fma_dot_seq_pkg;

    localparam int unsigned FDS_WIDTH = 32;
    localparam int unsigned FDS_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/fma_dot_seq_if.sv
// Command, element-stream and result-port bundle of the dot-product sequencer.
interface fma_dot_seq_if
    import fma_dot_seq_pkg::*;
#(
    parameter int unsigned WIDTH = FDS_WIDTH,
    parameter int unsigned LEN_W = FDS_LEN_W
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] init;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output start, len, init, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_data
    );

    modport slave (
        input  start, len, init, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/FXP_FMA.sv
// Signed fixed-point fused multiply-add, Q(W/2).(W/2): d = sat(round_half_up(a*b) + c).
module FXP_FMA #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);
    localparam int unsigned FRAC = WIDTH / 2;
    localparam int unsigned PW   = 2 * WIDTH;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_rnd;
    logic signed [PW-1:0] prod_sh;
    logic signed [PW-1:0] sum;
    logic                 fits;

    assign a_ext    = PW'($signed(a));
    assign b_ext    = PW'($signed(b));
    assign prod     = a_ext * b_ext;
    assign prod_rnd = prod + (PW'(1) << (FRAC - 1));
    assign prod_sh  = prod_rnd >>> FRAC;
    assign sum      = prod_sh + PW'($signed(c));

    // Result fits when every bit above the sign position agrees with it.
    assign fits = (&sum[PW-1:WIDTH-1]) || !(|sum[PW-1:WIDTH-1]);

    assign d = fits      ? sum[WIDTH-1:0] :
               sum[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                           {1'b0, {(WIDTH-1){1'b1}}};
endmodule

// File: rtl/fma_dot_seq.sv
// Dot-product sequencer: streams element pairs through one FXP_FMA into an accumulator.
module fma_dot_seq
    import fma_dot_seq_pkg::*;
#(
    parameter int unsigned WIDTH = FDS_WIDTH,
    parameter int unsigned LEN_W = FDS_LEN_W
) (
    input  logic         CLK,
    input  logic         RST,
    fma_dot_seq_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             busy_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] fma_d;

    FXP_FMA #(.WIDTH(WIDTH)) u_fma (
        .a (bus.in_a),
        .b (bus.in_b),
        .c (acc_q),
        .d (fma_d)
    );

    // Handshake flags are flopped decodes of the next state, so they track state_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            busy_q      <= (state_d != ST_IDLE);
            in_ready_q  <= (state_d == ST_RUN);
            out_valid_q <= (state_d == ST_HOLD);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = bus.init;
                    if (bus.len != '0) begin
                        rem_d   = bus.len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_RUN: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d = fma_d;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
endmodule

// File: tb/tb_fma_dot_seq.sv
// Randomized bench for fma_dot_seq against an integer-arithmetic dot-product model.
module tb_fma_dot_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fma_dot_seq_if bus ();

    fma_dot_seq dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          busy_cnt = 0;
    int          lat;
    logic [31:0] va[$];
    logic [31:0] vb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.busy) busy_cnt++;
    endtask

    // Q16.16: exact product, round half up, add c, clamp to the signed 32-bit range.
    function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = (p + 64'sd32768) >>> 16;
        p = p + longint'($signed(c));
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return p[31:0];
    endfunction

    function automatic logic [31:0] rnd_op(input bit wide);
        if (wide) return $urandom;
        return 32'($urandom_range(0, 32'h7_FFFF)) - 32'h4_0000;
    endfunction

    task automatic fill(input int n, input int wide_pct, input bit zero_a, input bit zero_b);
        va.delete();
        vb.delete();
        for (int i = 0; i < n; i++) begin
            va.push_back(zero_a ? 32'h0 : rnd_op($urandom_range(99) < wide_pct));
            vb.push_back(zero_b ? 32'h0 : rnd_op($urandom_range(99) < wide_pct));
        end
    endtask

    task automatic run_cmd(input int n, input logic [31:0] init_v, input int bubble_pct,
                           input int stall, output int lat_o);
        logic [31:0] exp_v;
        int          idx;
        int          cyc;
        bit          taken;
        exp_v = init_v;
        for (int i = 0; i < n; i++) exp_v = fma_ref(va[i], vb[i], exp_v);
        busy_cnt  = 0;
        bus.start = 1'b1;
        bus.len   = 8'(n);
        bus.init  = init_v;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        if (n > 0) chk("rdy_after_start", 32'(bus.in_ready), 32'd1);
        idx = 0;
        while (idx < n && cyc < 4 * n + 50) begin
            bus.in_valid = ($urandom_range(99) >= bubble_pct);
            bus.in_a     = va[idx];
            bus.in_b     = vb[idx];
            taken        = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (taken) idx++;
        end
        bus.in_valid = 1'b0;
        chk("elements_taken", 32'(idx), 32'(n));
        lat_o = cyc;
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("result", bus.out_data, exp_v);
        chk("in_ready_hold", 32'(bus.in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'($urandom_range(1));
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            bus.start    = 1'($urandom_range(1));
            bus.len      = 8'($urandom_range(1, 9));
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data", bus.out_data, exp_v);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.init      = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);

        // Reset mid-run after two of five elements.
        bus.start = 1'b1;
        bus.len   = 8'd5;
        bus.init  = $urandom;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = rnd_op(1'b0);
        bus.in_b     = rnd_op(1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_data", bus.out_data, 32'd0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        fill(1, 50, 1'b0, 1'b0);
        run_cmd(1, 32'h0, 0, 0, lat);
        chk("after_rst_lat", 32'(lat), 32'd2);

        // Zero length returns init the cycle after start.
        fill(0, 0, 1'b0, 1'b0);
        run_cmd(0, 32'h1234_5678, 0, 0, lat);
        chk("zero_len_lat", 32'(lat), 32'd1);

        // Zero multiplicand keeps init; result N+1 cycles after start.
        fill(3, 100, 1'b0, 1'b1);
        run_cmd(3, 32'hDEAD_BEEF, 0, 0, lat);
        chk("zero_b_lat", 32'(lat), 32'd4);

        // Long chain with input bubbles.
        fill(200, 10, 1'b0, 1'b0);
        run_cmd(200, rnd_op(1'b0), 30, 0, lat);

        // Output backpressure with ignored start/in_valid pulses.
        fill(6, 30, 1'b0, 1'b0);
        run_cmd(6, $urandom, 0, 10, lat);
        chk("bp_lat", 32'(lat), 32'd7);

        // Short random commands, full-range operands to reach saturation.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 12);
            fill(n, 100, 1'b0, 1'b0);
            run_cmd(n, $urandom, 20, $urandom_range(0, 3), lat);
        end

        // Maximum length: busy spans 256 cycles plus a 3-cycle output stall.
        fill(255, 0, 1'b1, 1'b1);
        run_cmd(255, 32'h0, 0, 3, lat);
        chk("max_len_lat", 32'(lat), 32'd256);
        chk("max_len_busy", 32'(busy_cnt), 32'd259);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
